uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. Detects each completed frame from the receiver's `ready`/`error`/`data_out` outputs and pushes one {error, data} entry per frame into a DEPTH-entry FIFO. The entries are presented to the consumer through a first-word-fall-through valid/ready read port. Also tracks overrun and a saturating frame-error count.

## Interface
- `WIDTH`, 8, data bits per frame; must equal the receiver's WIDTH.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `AW`, $clog2(DEPTH), pointer width (derived, not overridden).

- `rx_clk`  in  1  clock, shared with the receiver.
- `rx_reset`  in  1  asynchronous, active-low reset.
- `rx_ready`  in  1  receiver ready level; high for the whole final phase of a frame.
- `rx_error`  in  1  receiver error flag.
- `rx_data`  in  WIDTH  receiver data, LSB = first bit received.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  head entry available.
- `rd_data`  out  WIDTH  head entry data.
- `rd_error`  out  1  head entry error bit.
- `level`  out  AW+1  entries stored, 0..DEPTH.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `overrun`  out  1  sticky; a frame was dropped because the FIFO was full.
- `ovr_clr`  in  1  synchronous clear of `overrun`.
- `err_cnt`  out  8  frames with the error bit set; saturates at 255.

## Operation
- Reset values: all pointers 0; `level` 0; `rd_valid` 0; `empty` 1; `full` 0; `overrun` 0; `err_cnt` 0; `rd_data`/`rd_error` 0; `rdy_d` 0; shadow data/error 0.
- Frame capture:
  - Every cycle with `rx_ready`=1, the shadow register loads `rx_data`.
  - `rdy_d` is `rx_ready` delayed one cycle.
  - The push strobe fires on the falling edge: `rdy_d`=1 and `rx_ready`=0.
  - The pushed entry is {`rx_error` sampled in the push cycle, shadow data}. `rx_error` in that cycle carries both the parity and stop-bit results.
- Push when not full: write `mem[wr_ptr]`, advance `wr_ptr` (wraps modulo DEPTH), increment `level`.
- Push when full, with no pop in the same cycle: the entry is discarded, `overrun` is set, and `level` is unchanged.
- Push and pop in the same cycle while full: the push is accepted and `level` stays DEPTH. No overrun.
- Pop occurs when `rd_valid` && `rd_ready`: advance `rd_ptr`, decrement `level`. When empty, `rd_ready` is ignored.
- Push and pop in the same cycle while not empty: both occur and `level` is unchanged.
- `err_cnt` increments on every push strobe whose error bit is 1, whether or not the entry is stored. It holds at 255.
- `overrun`: a set in the same cycle as `ovr_clr` wins (stays 1).
- Reset mid-frame: everything returns to reset values. A frame whose falling edge occurs after reset release is captured normally. Shadow contents from before reset are never pushed.

## Timing
- Latency: push strobe in cycle T → `rd_valid`=1 in cycle T+1 when the FIFO was empty.
- `rd_data`/`rd_error` show `mem[rd_ptr]` (first-word fall-through). They are stable while `rd_valid`=1 and `rd_ready`=0.
- `level`, `full`, `empty` and `overrun` update one cycle after the push/pop event.
- Minimum spacing between push strobes is one frame, so back-to-back strobes need not be supported. Correctness is required for strobes 2 cycles apart.

## Configuration
- `UART_RX_FIFO_DROP_ERR_EN` defined:
  - Entries whose error bit is 1 are not written and do not cause overrun.
  - `err_cnt` still increments.
  - `rd_error` is tied to 0.
- `UART_RX_FIFO_DROP_ERR_EN` undefined: errored frames are stored with `rd_error`=1, as described above.

## Structure
- Shared package `uart_pkg`:
  - `uart_frame_t` packed struct {error, data[WIDTH-1:0]}.
  - `ERR_CNT_W`=8.
  - `ERR_CNT_MAX`=255.
- Sub-module `uart_fifo_ram`:
  - DEPTH × (WIDTH+1) storage.
  - Synchronous write port and asynchronous read port.
- Pointer, level, edge-detect and flag logic live in the top module.

## Test plan
- Single frame:
  - Stimulus: `rx_data`=0xA5, `rx_ready` high for 16 cycles then low, `rx_error`=0.
  - Response: `rd_valid` high 1 cycle after the fall; `rd_data`=0xA5, `rd_error`=0, `level`=1. Pop with `rd_ready`=1 → `level`=0, `empty`=1.
- Fill and overrun:
  - Stimulus: 17 frames 0x00..0x10 with no pops.
  - Response: `full`=1 after the 16th; the 17th (0x10) is dropped and `overrun`=1. Reading back gives 0x00..0x0F in order. `ovr_clr` pulse → `overrun`=0.
- Simultaneous push and pop at full:
  - Stimulus: with DEPTH entries stored, hold `rd_ready`=1 during a push strobe.
  - Response: `level` stays 16, `overrun` stays 0, and the new byte is last out.
- Error frame:
  - Stimulus: `rx_data`=0x3C, `rx_error`=1 in the push cycle.
  - Response without the macro: entry stored with `rd_error`=1, `err_cnt`=1.
  - Response with `UART_RX_FIFO_DROP_ERR_EN`: `level` stays 0, `err_cnt`=1.
- Reset mid-frame:
  - Stimulus: assert `rx_reset`=0 while `rx_ready`=1 with 3 entries stored.
  - Response: `level`=0, `rd_valid`=0, `err_cnt`=0 immediately.
- `err_cnt` saturation:
  - Stimulus: 260 error frames.
  - Response: `err_cnt`=255.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive-side types and constants.
package uart_pkg;

  localparam int unsigned FRAME_WIDTH = 8;
  localparam int unsigned ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  typedef struct packed {
    logic                   error;
    logic [FRAME_WIDTH-1:0] data;
  } uart_frame_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port.
module uart_fifo_ram #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: one {error,data} entry per frame, FWFT read port.
// Optional UART_RX_FIFO_DROP_ERR_EN discards errored frames instead of storing them.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 rx_clk,
  input  logic                 rx_reset,
  input  logic                 rx_ready,
  input  logic                 rx_error,
  input  logic [WIDTH-1:0]     rx_data,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_error,
  output logic [AW:0]          level,
  output logic                 full,
  output logic                 empty,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             rdy_d;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH:0]   ram_q;
  logic [WIDTH:0]   ram_d;
  logic             push, pop, store_req, wr_en, ovr_set;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign rd_valid = ~empty;

  // The frame is complete on the falling edge of the receiver's ready level.
  always_comb begin
    push      = rdy_d & ~rx_ready;
    pop       = rd_valid & rd_ready;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    store_req = push & ~rx_error;
    ram_d     = {1'b0, shadow};
`else
    store_req = push;
    ram_d     = {rx_error, shadow};
`endif
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    wr_en     = store_req & (~full | pop);
    ovr_set   = store_req & full & ~pop;
  end

  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      rdy_d   <= 1'b0;
      shadow  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
      err_cnt <= '0;
    end else begin
      rdy_d <= rx_ready;
      if (rx_ready) shadow <= rx_data;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      if (push && rx_error && err_cnt != ERR_CNT_MAX)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  uart_fifo_ram #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (rx_clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (ram_d),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign rd_data = rd_valid ? ram_q[WIDTH-1:0] : '0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign rd_error = 1'b0;
`else
  assign rd_error = rd_valid & ram_q[WIDTH];
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corners, random vs queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       rx_clk = 1'b0;
  logic       rx_reset = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rd_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       rd_valid, rd_error, full, empty, overrun;
  logic [7:0] rd_data, err_cnt;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  logic [8:0] mq[$];
  bit         m_ovr;
  int         m_ec;

  uart_rx_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .rx_clk(rx_clk), .rx_reset(rx_reset), .rx_ready(rx_ready), .rx_error(rx_error),
    .rx_data(rx_data), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_error(rd_error), .level(level), .full(full), .empty(empty),
    .overrun(overrun), .ovr_clr(ovr_clr), .err_cnt(err_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".level"}, 32'(level), 32'(n));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".rd_data"}, 32'(rd_data), (n != 0) ? 32'(mq[0][7:0]) : 32'd0);
    chk({tag, ".rd_error"}, 32'(rd_error), (n != 0) ? 32'(mq[0][8]) : 32'd0);
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_ec));
  endtask

  // Model update for one completed frame: an optional pop and the push share the final cycle.
  task automatic send_frame(input logic [7:0] d, input bit e, input int hi, input bit pp);
    bit store;
    rx_data  = d;
    rx_error = 1'b0;
    rx_ready = 1'b1;
    repeat (hi) step();
    rx_ready = 1'b0;
    rx_error = e;
    rd_ready = pp;
    if (pp && mq.size() > 0) void'(mq.pop_front());
`ifdef UART_RX_FIFO_DROP_ERR_EN
    store = !e;
`else
    store = 1'b1;
`endif
    if (store) begin
      if (mq.size() < DEPTH) mq.push_back({e, d});
      else m_ovr = 1'b1;
    end
    if (e && m_ec < 255) m_ec++;
    step();
    rx_error = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) begin
      pop_one();
      check_all(tag);
    end
  endtask

  task automatic do_reset();
    rx_reset = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    m_ec  = 0;
    step();
    rx_reset = 1'b1;
    step();
  endtask

  typedef struct {
    logic [7:0] d;
    bit         e;
    int         hi;
    bit         pp;
    int         lvl;
    logic [7:0] head;
    bit         herr;
    int         ec;
  } vec_t;

  vec_t tv[4];

  initial begin
`ifdef UART_RX_FIFO_DROP_ERR_EN
    tv[0] = '{8'hA5, 1'b0, 16, 1'b0, 1, 8'hA5, 1'b0, 0};
    tv[1] = '{8'h3C, 1'b1, 4,  1'b0, 1, 8'hA5, 1'b0, 1};
    tv[2] = '{8'h77, 1'b0, 3,  1'b1, 1, 8'h77, 1'b0, 1};
    tv[3] = '{8'h5A, 1'b0, 2,  1'b1, 1, 8'h5A, 1'b0, 1};
`else
    tv[0] = '{8'hA5, 1'b0, 16, 1'b0, 1, 8'hA5, 1'b0, 0};
    tv[1] = '{8'h3C, 1'b1, 4,  1'b0, 2, 8'hA5, 1'b0, 1};
    tv[2] = '{8'h77, 1'b0, 3,  1'b1, 2, 8'h3C, 1'b1, 1};
    tv[3] = '{8'h5A, 1'b0, 2,  1'b1, 2, 8'h77, 1'b0, 1};
`endif
    m_ovr = 1'b0;
    m_ec  = 0;

    repeat (3) step();
    check_all("reset");
    rx_reset = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      send_frame(tv[i].d, tv[i].e, tv[i].hi, tv[i].pp);
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(tv[i].lvl));
      chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(tv[i].head));
      chk($sformatf("vec%0d.rd_error", i), 32'(rd_error), 32'(tv[i].herr));
      chk($sformatf("vec%0d.err_cnt", i), 32'(err_cnt), 32'(tv[i].ec));
      check_all($sformatf("vec%0d", i));
    end
    drain("vec_drain");
    chk("vec_drain.empty", 32'(empty), 32'd1);

    // Fill and overrun
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b0, 3, 1'b0);
      if (i == 15) chk("fill.full16", 32'(full), 32'd1);
    end
    chk("fill.overrun", 32'(overrun), 32'd1);
    chk("fill.level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill.read%0d", i), 32'(rd_data), 32'(i));
      pop_one();
    end
    check_all("fill.after_read");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    m_ovr   = 1'b0;
    chk("fill.ovr_clr", 32'(overrun), 32'd0);

    // Simultaneous push and pop at full
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b0, 2, 1'b0);
    check_all("simul.full");
    send_frame(8'hEE, 1'b0, 2, 1'b1);
    chk("simul.level", 32'(level), 32'd16);
    chk("simul.overrun", 32'(overrun), 32'd0);
    check_all("simul.after");
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("simul.last_out", 32'(rd_data), 32'hEE);
      pop_one();
    end
    check_all("simul.drained");

    // Error frame from a fresh state
    do_reset();
    send_frame(8'h3C, 1'b1, 4, 1'b0);
    chk("errf.err_cnt", 32'(err_cnt), 32'd1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    chk("errf.level", 32'(level), 32'd0);
`else
    chk("errf.rd_error", 32'(rd_error), 32'd1);
    chk("errf.rd_data", 32'(rd_data), 32'h3C);
`endif
    check_all("errf");

    // Reset mid-frame, then a frame finishing after release
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'(8'h40 + i), 1'b0, 2, 1'b0);
    send_frame(8'h99, 1'b1, 2, 1'b0);
    check_all("rstmid.pre");
    rx_data  = 8'h66;
    rx_ready = 1'b1;
    step();
    step();
    rx_reset = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    m_ec  = 0;
    chk("rstmid.level", 32'(level), 32'd0);
    chk("rstmid.rd_valid", 32'(rd_valid), 32'd0);
    chk("rstmid.err_cnt", 32'(err_cnt), 32'd0);
    step();
    rx_reset = 1'b1;
    rx_data  = 8'hC3;
    send_frame(8'hC3, 1'b0, 3, 1'b0);
    check_all("rstmid.post");
    drain("rstmid.drain");

    // err_cnt saturation
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send_frame(8'(i), 1'b1, 1, 1'b1);
      if (i == 254) chk("sat.at255", 32'(err_cnt), 32'd255);
    end
    chk("sat.err_cnt", 32'(err_cnt), 32'd255);
    check_all("sat");
    drain("sat.drain");

    // Randomised traffic against the queue model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        send_frame(8'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(1, 5)),
                   1'($urandom_range(0, 1)));
      end else if (op <= 7) begin
        pop_one();
      end else if (op == 8) begin
        step();
      end else begin
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        m_ovr   = 1'b0;
      end
      check_all($sformatf("rand%0d", i));
    end
    drain("rand.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
